pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central stall/flush scheduler for the 5-stage pipeline (IF, ID, EX, MEM, WB). It merges the stall and flush requests raised by the different pipeline stages and turns them into one consistent set of per-register enables and flushes. The requests it handles are load-use hazards, multi-cycle divide, data-memory wait, branch redirect and exceptions. It holds two concurrent sequencers: a divide-latency counter and a memory-wait tracker.

## Interface
- `DIV_CYCLES`, default 32: EX-stage stall cycles per divide. Legal range 2..63.
- `clk`  in  1  Clock. All state updates on the rising edge.
- `resetn`  in  1  Synchronous, active-low reset.
- `ld_use`  in  1  Load-use hazard reported by the ID-stage hazard detector.
- `ex_div`  in  1  Instruction in EX is a divide.
- `mem_req`  in  1  MEM stage is issuing a data-memory access.
- `mem_ack`  in  1  Data memory has completed the access.
- `br_taken`  in  1  Branch in EX resolved as taken.
- `exc_req`  in  1  Exception request. Held high by the source until `exc_ack`.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  Register write enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  Bubble inserts. A flush wins over the matching enable.
- `exc_ack`  out  1  Exception accepted (one-cycle pulse).
- `div_busy`  out  1  Divide sequencer active.
- `div_done`  out  1  One-cycle pulse in the cycle the divide result is allowed to advance.
- `perf_stall_cycles`  out  32  Stall counter. See Configuration.

## Operation
- All outputs are combinational from the registered state plus the current inputs.
- Stall terms:
  - `mem_stall` = (`mem_wait` | (`mem_req` & !`mem_ack`)) & !(`mem_wait` & `mem_ack`).
  - `div_stall` = (`div_busy` & (`cnt` != 0)) | (!`div_busy` & `ex_div` & !`flush_all`).
- Priority, highest first. Only the highest active term shapes the outputs.
  - **Reset:** `resetn`=0. All enables = 1, all flushes = 1, `exc_ack`=0.
  - **Memory wait:** `mem_stall`. PC, IF/ID, ID/EX and EX/MEM are held. `memwb_flush`=1.
  - **Exception:** `exc_req` & !`mem_stall`. `exc_ack`=1. `pc_en`=1. Flush IF/ID, ID/EX and EX/MEM. The divide sequencer aborts (`flush_all`).
  - **Divide stall:** `div_stall` or divide hold. PC, IF/ID and ID/EX are held. `exmem_flush`=1.
  - **Branch:** `br_taken` (taken only when EX is not held). `pc_en`=1. Flush IF/ID and ID/EX. A simultaneous `ld_use` is ignored because it is wrong-path.
  - **Load-use:** `ld_use`. PC and IF/ID are held. `idex_flush`=1.
  - **Otherwise:** all enables = 1, all flushes = 0.
- Memory-wait tracker (`mem_wait` flag):
  - Set when `mem_req` & !`mem_ack` and no `mem_wait`.
  - Cleared on `mem_ack`. The ack cycle itself does not stall.
- Divide sequencer (states IDLE and BUSY):
  - IDLE→BUSY on `ex_div` & !`flush_all`. Loads `cnt` = `DIV_CYCLES`-1. This cycle stalls.
  - In BUSY, `cnt` decrements every cycle down to 0, including during memory wait.
  - BUSY with `cnt`==0 and !`mem_stall`: pulse `div_done`, no divide stall, go to IDLE. Total EX hold = `DIV_CYCLES` cycles.
  - BUSY with `cnt`==0 and `mem_stall`: stay in BUSY ("divide hold") and defer `div_done`.
  - BUSY with `flush_all`: go to IDLE immediately, `cnt`=0, no `div_done`.
- `ex_div` in the `div_done` cycle belongs to the same instruction and does not retrigger. It is sampled again from the next cycle.

## Timing
- Reset values: `mem_wait`=0, state IDLE, `cnt`=0, `div_done`=0, `div_busy`=0, `exc_ack`=0, `perf_stall_cycles`=0.
- Reset applied mid-divide or mid-wait returns to IDLE and clears `mem_wait` at the next edge. No `div_done` is emitted.
- Request-to-output latency: 0 cycles (combinational). State-update latency: 1 cycle.
- `exc_ack` can rise no earlier than the cycle in which `mem_stall` falls.

## Configuration
- `PIPE_STALL_CTRL_PERF_EN` defined:
  - `perf_stall_cycles` counts cycles with `pc_en`=0 while `resetn`=1.
  - Saturates at 0xFFFF_FFFF.
- Not defined: `perf_stall_cycles` is constant 0 and the counter logic is not built.

## Test plan
- **Load-use:** `ld_use`=1 for 1 cycle → `pc_en`=0, `ifid_en`=0, `idex_flush`=1 for exactly that cycle. All other outputs are nominal.
- **Divide:** `DIV_CYCLES`=4, `ex_div` held → `idex_en`=0 for 4 cycles, `div_done` pulses in cycle 5, `div_busy` falls after it, and there is no retrigger.
- **Memory wait:** `mem_req`=1, `mem_ack` rises 3 cycles later → `exmem_en`=0 and `memwb_flush`=1 for 3 cycles. The ack cycle has `pc_en`=1. `mem_req`=`mem_ack`=1 in the same cycle → no stall.
- **Divide/memory overlap:** divide with `cnt` reaching 0 during a 5-cycle memory wait → `div_done` is deferred to the first cycle with `mem_stall`=0.
- **Exception:** `exc_req` raised during BUSY with `cnt`=10 → `exc_ack` in that cycle, IF/ID, ID/EX and EX/MEM are flushed, the sequencer is IDLE next cycle, and `div_done` never pulses.
- **Branch and perf counter:** `br_taken`+`ld_use` together → `ifid_flush`=`idex_flush`=1, `pc_en`=1. With the macro defined, a 7-cycle stall window → `perf_stall_cycles`=7.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// rtl/pipe_stall_ctrl_if.sv - request/control bundle between the pipeline stages and the stall scheduler
//
// Purpose: groups every hazard request raised by the pipeline stages and every
// per-register enable/flush driven back by pipe_stall_ctrl.
// Signals:
//   requests (master -> slave): ld_use, ex_div, mem_req, mem_ack, br_taken, exc_req
//   controls (slave -> master): pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                               ifid_flush, idex_flush, exmem_flush, memwb_flush,
//                               exc_ack, div_busy, div_done, perf_stall_cycles[31:0]
// Modports: master = pipeline side, slave = scheduler side.

interface pipe_stall_ctrl_if;
  logic        ld_use;
  logic        ex_div;
  logic        mem_req;
  logic        mem_ack;
  logic        br_taken;
  logic        exc_req;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        exc_ack;
  logic        div_busy;
  logic        div_done;
  logic [31:0] perf_stall_cycles;

  modport master (
    output ld_use, ex_div, mem_req, mem_ack, br_taken, exc_req,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
    input  exc_ack, div_busy, div_done, perf_stall_cycles
  );

  modport slave (
    input  ld_use, ex_div, mem_req, mem_ack, br_taken, exc_req,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush,
    output exc_ack, div_busy, div_done, perf_stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// rtl/pipe_stall_ctrl.sv - central stall/flush scheduler for the 5-stage pipeline
//
// Purpose: merges load-use, divide, data-memory wait, branch and exception
// requests into one consistent set of register enables and bubble inserts.
// Two concurrent sequencers: a divide-latency counter and a memory-wait flag.
// Parameters:
//   DIV_CYCLES  EX-stage stall cycles per divide (2..63)
// Ports:
//   clk     rising-edge clock
//   resetn  synchronous active-low reset
//   bus     pipe_stall_ctrl_if.slave (requests in, enables/flushes/status out)
// Optional feature macro: PIPE_STALL_CTRL_PERF_EN
//   defined   -> perf_stall_cycles counts saturating cycles with pc_en=0
//   undefined -> perf_stall_cycles is tied to 0

module pipe_stall_ctrl #(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic            clk,
  input  logic            resetn,
  pipe_stall_ctrl_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

  logic [0:0] state;
  logic [5:0] cnt;
  logic       mem_wait;

  logic       busy;
  logic       cnt_zero;
  logic       mem_stall;
  logic       flush_all;
  logic       div_stall;
  logic       div_hold;
  logic       div_done;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic exc_ack;

  assign busy     = (state == ST_BUSY);
  assign cnt_zero = (cnt == 6'd0);

  // An ack in the same cycle as the outstanding wait releases the stall at once.
  assign mem_stall = (mem_wait | (bus.mem_req & ~bus.mem_ack)) & ~(mem_wait & bus.mem_ack);

  // Exceptions are only taken once memory has settled, so exc_ack never
  // precedes the falling edge of mem_stall.
  assign flush_all = bus.exc_req & ~mem_stall;

  assign div_stall = (busy & ~cnt_zero) | (~busy & bus.ex_div & ~flush_all);
  assign div_hold  = busy & cnt_zero & mem_stall;

  // The result may only advance when MEM is moving; an exception kills it.
  assign div_done  = resetn & busy & cnt_zero & ~mem_stall & ~flush_all;

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    exc_ack     = 1'b0;
    if (!resetn) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (flush_all) begin
      exc_ack     = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (div_stall || div_hold) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (bus.br_taken) begin
      // Any concurrent ld_use belongs to the wrong path and is dropped here.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end else if (bus.ld_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_wait <= 1'b0;
    end else if (!mem_wait && bus.mem_req && !bus.mem_ack) begin
      mem_wait <= 1'b1;
    end else if (bus.mem_ack) begin
      mem_wait <= 1'b0;
    end
  end

  // Divide sequencer. cnt keeps running during a memory wait; once it hits
  // zero the sequencer parks in BUSY until MEM releases.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= 6'd0;
    end else if (state == ST_IDLE) begin
      if (bus.ex_div && !flush_all) begin
        state <= ST_BUSY;
        cnt   <= CNT_LOAD;
      end
    end else if (flush_all) begin
      state <= ST_IDLE;
      cnt   <= 6'd0;
    end else if (cnt_zero) begin
      if (!mem_stall) begin
        state <= ST_IDLE;
      end
    end else begin
      cnt <= cnt - 6'd1;
    end
  end

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_cnt <= 32'd0;
    end else if (!pc_en && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_cnt;
`else
  assign bus.perf_stall_cycles = 32'd0;
`endif

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.idex_en     = idex_en;
  assign bus.exmem_en    = exmem_en;
  assign bus.memwb_en    = memwb_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_flush  = idex_flush;
  assign bus.exmem_flush = exmem_flush;
  assign bus.memwb_flush = memwb_flush;
  assign bus.exc_ack     = exc_ack;
  assign bus.div_busy    = busy;
  assign bus.div_done    = div_done;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb/tb_pipe_stall_ctrl.sv - scoreboard bench for pipe_stall_ctrl with DIV_CYCLES=4

module tb_pipe_stall_ctrl;

  localparam int K_RST = 0;
  localparam int K_MEM = 1;
  localparam int K_EXC = 2;
  localparam int K_DIV = 3;
  localparam int K_BR  = 4;
  localparam int K_LU  = 5;
  localparam int K_NOM = 6;

  // input vector order: {ld_use, ex_div, mem_req, mem_ack, br_taken, exc_req}
  localparam logic [5:0] I0 = 6'b000000;
  localparam logic [5:0] LU = 6'b100000;
  localparam logic [5:0] DV = 6'b010000;
  localparam logic [5:0] MR = 6'b001000;
  localparam logic [5:0] MA = 6'b000100;
  localparam logic [5:0] BR = 6'b000010;
  localparam logic [5:0] EX = 6'b000001;

  typedef struct {
    logic [11:0] ctl;
    logic [31:0] perf;
    int          id;
  } exp_t;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  int   vec_id;
  logic [31:0] perf_model;
  exp_t q[$];

  pipe_stall_ctrl_if b();

  pipe_stall_ctrl #(.DIV_CYCLES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,exmem_f,memwb_f, exc_ack}
  function automatic logic [9:0] kind_bits(input int k);
    case (k)
      K_RST:   kind_bits = 10'b11111_1111_0;
      K_MEM:   kind_bits = 10'b00001_0001_0;
      K_EXC:   kind_bits = 10'b11111_1110_1;
      K_DIV:   kind_bits = 10'b00011_0010_0;
      K_BR:    kind_bits = 10'b11111_1100_0;
      K_LU:    kind_bits = 10'b00111_0100_0;
      default: kind_bits = 10'b11111_0000_0;
    endcase
  endfunction

  task automatic step(input logic rn, input logic [5:0] in, input int k,
                      input logic busy, input logic done);
    exp_t e;
    @(posedge clk);
    #1;
    resetn = rn;
    {b.ld_use, b.ex_div, b.mem_req, b.mem_ack, b.br_taken, b.exc_req} = in;
    e.ctl = {kind_bits(k), busy, done};
`ifdef PIPE_STALL_CTRL_PERF_EN
    e.perf = perf_model;
`else
    e.perf = 32'd0;
`endif
    e.id = vec_id;
    vec_id++;
    q.push_back(e);
    if (!rn) perf_model = 32'd0;
    else if (!e.ctl[11]) perf_model = perf_model + 32'd1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [11:0] got;
      e = q.pop_front();
      got = {b.pc_en, b.ifid_en, b.idex_en, b.exmem_en, b.memwb_en,
             b.ifid_flush, b.idex_flush, b.exmem_flush, b.memwb_flush,
             b.exc_ack, b.div_busy, b.div_done};
      total++;
      if (got !== e.ctl) begin
        bad++;
        $display("FAIL ctl vec%0d: got %b want %b", e.id, got, e.ctl);
      end
      total++;
      if (b.perf_stall_cycles !== e.perf) begin
        bad++;
        $display("FAIL perf vec%0d: got %0d want %0d", e.id, b.perf_stall_cycles, e.perf);
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    vec_id = 0;
    perf_model = 32'd0;
    resetn = 1'b0;
    {b.ld_use, b.ex_div, b.mem_req, b.mem_ack, b.br_taken, b.exc_req} = I0;

    @(posedge clk);
    step(0, I0, K_RST, 0, 0);
    step(1, I0, K_NOM, 0, 0);

    // load-use single cycle
    step(1, LU, K_LU, 0, 0);
    step(1, I0, K_NOM, 0, 0);

    // divide, ex_div held through the done cycle
    step(1, DV, K_DIV, 0, 0);
    for (int i = 0; i < 3; i++) step(1, DV, K_DIV, 1, 0);
    step(1, DV, K_NOM, 1, 1);
    step(1, I0, K_NOM, 0, 0);

    // memory wait of 3 cycles, then same-cycle req/ack
    for (int i = 0; i < 3; i++) step(1, MR, K_MEM, 0, 0);
    step(1, MR | MA, K_NOM, 0, 0);
    step(1, MR | MA, K_NOM, 0, 0);
    step(1, I0, K_NOM, 0, 0);

    // divide reaching cnt=0 inside a 5-cycle memory wait
    step(1, DV, K_DIV, 0, 0);
    for (int i = 0; i < 5; i++) step(1, DV | MR, K_MEM, 1, 0);
    step(1, DV | MA, K_NOM, 1, 1);
    step(1, I0, K_NOM, 0, 0);

    // exception mid-divide
    step(1, DV, K_DIV, 0, 0);
    step(1, DV, K_DIV, 1, 0);
    step(1, DV | EX, K_EXC, 1, 0);
    step(1, I0, K_NOM, 0, 0);
    step(1, I0, K_NOM, 0, 0);

    // exception held behind a memory wait
    step(1, MR | EX, K_MEM, 0, 0);
    step(1, EX, K_MEM, 0, 0);
    step(1, MA | EX, K_EXC, 0, 0);
    step(1, I0, K_NOM, 0, 0);

    // branch beats load-use; divide beats branch
    step(1, BR | LU, K_BR, 0, 0);
    step(1, BR, K_BR, 0, 0);
    step(1, BR | DV, K_DIV, 0, 0);
    for (int i = 0; i < 3; i++) step(1, DV, K_DIV, 1, 0);
    step(1, DV, K_NOM, 1, 1);
    step(1, I0, K_NOM, 0, 0);

    // reset mid-divide
    step(1, DV, K_DIV, 0, 0);
    step(1, DV, K_DIV, 1, 0);
    step(0, DV, K_RST, 1, 0);
    step(1, I0, K_NOM, 0, 0);

    // 7-cycle stall window for the perf counter
    for (int i = 0; i < 7; i++) step(1, LU, K_LU, 0, 0);
    step(1, I0, K_NOM, 0, 0);

    // reset mid-wait clears mem_wait
    step(1, MR, K_MEM, 0, 0);
    step(0, I0, K_RST, 0, 0);
    step(1, I0, K_NOM, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
